// File: rtl/sccb_config_scheduler.sv
// Walks the OV7670 init ROM for CAM1 then CAM2, then round-robin arbitrates runtime writes onto one SCCB master.
// Optional NACK retry is compiled in with `define SCCB_SCHED_RETRY_EN.
module sccb_config_scheduler #(
    parameter int ROM_AW        = 8,
    parameter int SETTLE_CYCLES = 1_000_000,
    parameter int MAX_RETRY     = 3,
    parameter int ERR_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic              sccb_start_o,
    output logic              sccb_cam_sel_o,
    output logic [7:0]        sccb_reg_o,
    output logic [7:0]        sccb_val_o,
    input  logic              sccb_busy_i,
    input  logic              sccb_done_i,
    input  logic              sccb_nack_i,
    input  logic [1:0]        req_valid_i,
    input  logic [1:0]        req_cam_i,
    input  logic [15:0]       req_reg_i,
    input  logic [15:0]       req_val_i,
    output logic [1:0]        req_ready_o,
    output logic [1:0]        init_done_o,
    output logic              busy_o,
    output logic [ERR_W-1:0]  err_cnt_o
);

    // state    | meaning
    // IDLE     | waiting for start after reset
    // FETCH    | ROM address presented
    // ROM_WAIT | ROM word valid, capture or detect end of table
    // ISSUE    | wait for master idle, then launch write
    // WAIT     | write in flight, wait for done
    // SETTLE   | post soft-reset delay
    // NEXT     | advance ROM pointer or return to READY
    // READY    | init complete, serving runtime requests
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_ROM_WAIT = 3'd2;
    localparam logic [2:0] S_ISSUE    = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_SETTLE   = 3'd5;
    localparam logic [2:0] S_NEXT     = 3'd6;
    localparam logic [2:0] S_READY    = 3'd7;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [2:0]        state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              cam_q, cam_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        val_q, val_d;
    logic              sccb_start_q, sccb_start_d;
    logic [1:0]        req_ready_q, req_ready_d;
    logic [1:0]        init_done_q, init_done_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              rr_q, rr_d;
    logic              init_mode_q, init_mode_d;
    logic [SW-1:0]     settle_q, settle_d;
`ifdef SCCB_SCHED_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0]     retry_q, retry_d;
`endif

    logic table_end;
    logic do_start;
    logic grant_port;
    logic soft_reset_wr;

    assign soft_reset_wr = (reg_q == 8'h12) && (val_q == 8'h80);

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        cam_d        = cam_q;
        reg_d        = reg_q;
        val_d        = val_q;
        sccb_start_d = 1'b0;
        req_ready_d  = 2'b00;
        init_done_d  = init_done_q;
        err_d        = err_q;
        rr_d         = rr_q;
        init_mode_d  = init_mode_q;
        settle_d     = settle_q;
`ifdef SCCB_SCHED_RETRY_EN
        retry_d      = retry_q;
`endif
        table_end    = 1'b0;
        do_start     = 1'b0;
        grant_port   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) do_start = 1'b1;
            end
            S_FETCH: begin
                state_d = S_ROM_WAIT;
            end
            S_ROM_WAIT: begin
                if (rom_data_i == 16'hFFFF) begin
                    table_end = 1'b1;
                end else begin
                    reg_d   = rom_data_i[15:8];
                    val_d   = rom_data_i[7:0];
`ifdef SCCB_SCHED_RETRY_EN
                    retry_d = '0;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!sccb_busy_i) begin
                    sccb_start_d = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sccb_done_i) begin
                    if (!sccb_nack_i) begin
                        if (soft_reset_wr) begin
                            settle_d = SW'(SETTLE_CYCLES - 1);
                            state_d  = S_SETTLE;
                        end else begin
                            state_d = S_NEXT;
                        end
                    end else begin
`ifdef SCCB_SCHED_RETRY_EN
                        if (retry_q < RW'(MAX_RETRY)) begin
                            retry_d = retry_q + RW'(1);
                            state_d = S_ISSUE;
                        end else begin
                            if (err_q != '1) err_d = err_q + ERR_W'(1);
                            state_d = S_NEXT;
                        end
`else
                        if (err_q != '1) err_d = err_q + ERR_W'(1);
                        state_d = S_NEXT;
`endif
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) state_d = S_NEXT;
                else                settle_d = settle_q - SW'(1);
            end
            S_NEXT: begin
                if (init_mode_q) begin
                    // A table filling the whole ROM ends without an explicit marker.
                    if (rom_addr_q == '1) begin
                        table_end = 1'b1;
                    end else begin
                        rom_addr_d = rom_addr_q + ROM_AW'(1);
                        state_d    = S_FETCH;
                    end
                end else begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (start_i) begin
                    do_start = 1'b1;
                end else if (req_valid_i != 2'b00) begin
                    grant_port  = (req_valid_i == 2'b11) ? rr_q : req_valid_i[1];
                    req_ready_d = grant_port ? 2'b10 : 2'b01;
                    cam_d       = req_cam_i[grant_port];
                    reg_d       = grant_port ? req_reg_i[15:8] : req_reg_i[7:0];
                    val_d       = grant_port ? req_val_i[15:8] : req_val_i[7:0];
                    rr_d        = ~grant_port;
`ifdef SCCB_SCHED_RETRY_EN
                    retry_d     = '0;
`endif
                    state_d     = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (table_end) begin
            init_done_d[cam_q] = 1'b1;
            if (!cam_q) begin
                cam_d      = 1'b1;
                rom_addr_d = '0;
                state_d    = S_FETCH;
            end else begin
                init_mode_d = 1'b0;
                state_d     = S_READY;
            end
        end

        if (do_start) begin
            rom_addr_d  = '0;
            cam_d       = 1'b0;
            init_done_d = 2'b00;
            init_mode_d = 1'b1;
            state_d     = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rom_addr_q   <= '0;
            cam_q        <= 1'b0;
            reg_q        <= '0;
            val_q        <= '0;
            sccb_start_q <= 1'b0;
            req_ready_q  <= 2'b00;
            init_done_q  <= 2'b00;
            err_q        <= '0;
            rr_q         <= 1'b0;
            init_mode_q  <= 1'b0;
            settle_q     <= '0;
`ifdef SCCB_SCHED_RETRY_EN
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            cam_q        <= cam_d;
            reg_q        <= reg_d;
            val_q        <= val_d;
            sccb_start_q <= sccb_start_d;
            req_ready_q  <= req_ready_d;
            init_done_q  <= init_done_d;
            err_q        <= err_d;
            rr_q         <= rr_d;
            init_mode_q  <= init_mode_d;
            settle_q     <= settle_d;
`ifdef SCCB_SCHED_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    assign rom_addr_o     = rom_addr_q;
    assign sccb_start_o   = sccb_start_q;
    assign sccb_cam_sel_o = cam_q;
    assign sccb_reg_o     = reg_q;
    assign sccb_val_o     = val_q;
    assign req_ready_o    = req_ready_q;
    assign init_done_o    = init_done_q;
    assign err_cnt_o      = err_q;
    assign busy_o         = (state_q != S_IDLE) && (state_q != S_READY);

endmodule

// File: tb/tb_sccb_config_scheduler.sv
// Directed bench for sccb_config_scheduler: init sequencing, settle delay, arbitration, NACK handling, reset.
module tb_sccb_config_scheduler;
    localparam int AW     = 4;
    localparam int SETTLE = 20;
    localparam int MAXR   = 3;
`ifdef SCCB_SCHED_RETRY_EN
    localparam int ATT = MAXR + 1;
`else
    localparam int ATT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          sccb_start, sccb_cam_sel;
    logic [7:0]    sccb_reg, sccb_val;
    logic          sccb_busy, sccb_done, sccb_nack;
    logic [1:0]    req_valid, req_cam;
    logic [15:0]   req_reg, req_val;
    logic [1:0]    req_ready, init_done;
    logic          busy;
    logic [7:0]    err_cnt;

    always #5 clk = ~clk;

    sccb_config_scheduler #(.ROM_AW(AW), .SETTLE_CYCLES(SETTLE), .MAX_RETRY(MAXR), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .start_i(start),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .sccb_start_o(sccb_start), .sccb_cam_sel_o(sccb_cam_sel),
        .sccb_reg_o(sccb_reg), .sccb_val_o(sccb_val),
        .sccb_busy_i(sccb_busy), .sccb_done_i(sccb_done), .sccb_nack_i(sccb_nack),
        .req_valid_i(req_valid), .req_cam_i(req_cam), .req_reg_i(req_reg), .req_val_i(req_val),
        .req_ready_o(req_ready), .init_done_o(init_done), .busy_o(busy), .err_cnt_o(err_cnt)
    );

    logic [15:0] rom_mem [16];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SCCB master model: logs each launched write, busy for 3 cycles, then a done pulse.
    int          nw = 0;
    int          nacks_given = 0;
    int          nack_budget = 0;
    logic [16:0] log_w [64];
    int          log_t [64];
    logic [1:0]  log_d [64];

    initial begin
        sccb_busy = 1'b0;
        sccb_done = 1'b0;
        sccb_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (sccb_start === 1'b1) begin
                if (nw < 64) begin
                    log_w[nw] = {sccb_cam_sel, sccb_reg, sccb_val};
                    log_t[nw] = cyc;
                    log_d[nw] = init_done;
                end
                nw++;
                sccb_busy = 1'b1;
                repeat (3) @(negedge clk);
                if (nacks_given < nack_budget) begin
                    sccb_nack = 1'b1;
                    nacks_given++;
                end
                sccb_done = 1'b1;
                @(negedge clk);
                sccb_done = 1'b0;
                sccb_nack = 1'b0;
                sccb_busy = 1'b0;
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         b;
        int         ng;
        int         dbl;
        int         early;
        logic [1:0] prev;
        logic [1:0] gr [4];
        int         gt [4];

        reset     = 1'b1;
        start     = 1'b0;
        req_valid = 2'b00;
        req_cam   = 2'b10;
        req_reg   = {8'hA1, 8'hA0};
        req_val   = {8'hB1, 8'hB0};
        for (int i = 0; i < 16; i++) rom_mem[i] = 16'hFFFF;
        repeat (3) @(negedge clk);

        check("rst_busy",      {31'd0, busy},       32'd0);
        check("rst_init_done", {30'd0, init_done},  32'd0);
        check("rst_err_cnt",   {24'd0, err_cnt},    32'd0);
        check("rst_rom_addr",  {28'd0, rom_addr},   32'd0);
        check("rst_sccb_start",{31'd0, sccb_start}, 32'd0);
        check("rst_req_ready", {30'd0, req_ready},  32'd0);
        reset = 1'b0;

        // T1: two plain entries per camera
        rom_mem[0] = 16'h1180;
        rom_mem[1] = 16'h8C00;
        rom_mem[2] = 16'hFFFF;
        b = nw;
        pulse_start();
        wait_idle("t1_idle", 2000);
        check("t1_nwrites",  nw - b,                   32'd4);
        check("t1_w0",       {15'd0, log_w[b+0]},      {15'd0, 17'h01180});
        check("t1_w1",       {15'd0, log_w[b+1]},      {15'd0, 17'h08C00});
        check("t1_w2",       {15'd0, log_w[b+2]},      {15'd0, 17'h11180});
        check("t1_w3",       {15'd0, log_w[b+3]},      {15'd0, 17'h18C00});
        check("t1_done_mid", {30'd0, log_d[b+2]},      32'd1);
        check("t1_gap",      log_t[b+1] - log_t[b+0],  32'd8);
        check("t1_init_done",{30'd0, init_done},       32'd3);
        check("t1_err",      {24'd0, err_cnt},         32'd0);

        // T2: soft reset entry inserts the settle delay; restart from READY clears init_done
        rom_mem[0] = 16'h1280;
        rom_mem[1] = 16'h3A04;
        rom_mem[2] = 16'hFFFF;
        b = nw;
        pulse_start();
        check("t2_init_clear", {30'd0, init_done}, 32'd0);
        wait_idle("t2_idle", 2000);
        check("t2_nwrites",   nw - b,                   32'd4);
        check("t2_settle_c1", log_t[b+1] - log_t[b+0],  SETTLE + 8);
        check("t2_w1",        {15'd0, log_w[b+1]},      {15'd0, 17'h03A04});
        check("t2_settle_c2", log_t[b+3] - log_t[b+2],  SETTLE + 8);
        check("t2_init_done", {30'd0, init_done},       32'd3);

        // T3: both ports held valid -> alternating grants starting at port 0
        b = nw;
        ng = 0;
        dbl = 0;
        prev = 2'b00;
        req_valid = 2'b11;
        for (int k = 0; k < 400 && ng < 4; k++) begin
            @(negedge clk);
            if (req_ready !== 2'b00) begin
                if (prev !== 2'b00) dbl++;
                gr[ng] = req_ready;
                gt[ng] = cyc;
                ng++;
            end
            prev = req_ready;
        end
        req_valid = 2'b00;
        check("t3_ngrants", ng, 32'd4);
        check("t3_g0", {30'd0, gr[0]}, 32'd1);
        check("t3_g1", {30'd0, gr[1]}, 32'd2);
        check("t3_g2", {30'd0, gr[2]}, 32'd1);
        check("t3_g3", {30'd0, gr[3]}, 32'd2);
        check("t3_multi_cycle_ready", dbl, 32'd0);
        @(negedge clk);
        check("t3_ready_single", {30'd0, req_ready}, 32'd0);
        wait_idle("t3_idle", 500);
        check("t3_nwrites", nw - b, 32'd4);
        check("t3_bus0", {15'd0, log_w[b+0]}, {15'd0, 17'h0A0B0});
        check("t3_bus1", {15'd0, log_w[b+1]}, {15'd0, 17'h1A1B1});
        check("t3_bus2", {15'd0, log_w[b+2]}, {15'd0, 17'h0A0B0});
        check("t3_bus3", {15'd0, log_w[b+3]}, {15'd0, 17'h1A1B1});
        check("t3_latency", log_t[b+0] - gt[0], 32'd1);

        // single valid port wins regardless of the pointer (pointer now at port 0)
        b = nw;
        ng = 0;
        req_valid = 2'b10;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready !== 2'b00) begin
                gr[0] = req_ready;
                ng = 1;
                break;
            end
        end
        req_valid = 2'b00;
        check("t3_single_grant", {30'd0, gr[0]}, 32'd2);
        wait_idle("t3_single_idle", 200);
        check("t3_single_bus", {15'd0, log_w[b+0]}, {15'd0, 17'h1A1B1});

        // T4: first write NACKed on every attempt
        rom_mem[0] = 16'h3B0A;
        rom_mem[1] = 16'h3C0B;
        rom_mem[2] = 16'hFFFF;
        nack_budget = nacks_given + ATT;
        b = nw;
        pulse_start();
        wait_idle("t4_idle", 3000);
        check("t4_nwrites",  nw - b,                    ATT + 3);
        check("t4_last_try", {15'd0, log_w[b+ATT-1]},   {15'd0, 17'h03B0A});
        check("t4_next",     {15'd0, log_w[b+ATT]},     {15'd0, 17'h03C0B});
        check("t4_cam2",     {15'd0, log_w[b+ATT+1]},   {15'd0, 17'h13B0A});
        check("t4_err",      {24'd0, err_cnt},          32'd1);

        // T5a: requests held off during init
        pulse_start();
        req_valid = 2'b01;
        early = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (req_ready !== 2'b00) early++;
            if (init_done === 2'b11) break;
        end
        check("t5_init_done", {30'd0, init_done}, 32'd3);
        check("t5_no_early_ready", early, 32'd0);
        @(negedge clk);
        check("t5_ready_after", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        wait_idle("t5_idle", 200);

        // T5b: reset while a write is in flight
        pulse_start();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sccb_start === 1'b1) break;
        end
        check("t5_saw_start", {31'd0, sccb_start}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_start",     {31'd0, sccb_start}, 32'd0);
        check("t5_rst_init_done", {30'd0, init_done},  32'd0);
        check("t5_rst_busy",      {31'd0, busy},       32'd0);
        check("t5_rst_rom_addr",  {28'd0, rom_addr},   32'd0);
        check("t5_rst_err",       {24'd0, err_cnt},    32'd0);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_post_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
